ysyx_22040750_axi_arbiter: RTL
==============================

YSYX_22040750_AXI_ARBITER -- requirements
Module: ysyx_22040750_axi_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_W, default 64, AXI data width.
REQ-003 SHALL have port I_clk, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port I_rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have icache read request ports, all from icache, read-only requester:
- I_icache_arvalid, input, 1.
- I_icache_araddr, input, ADDR_W.
- I_icache_arlen, input, 8.
- I_icache_arsize, input, 3.
- O_icache_arready, output, 1.
REQ-006 SHALL have icache read return ports: O_icache_rvalid, output, 1; O_icache_rdata, output, DATA_W; O_icache_rlast, output, 1; I_icache_rready, input, 1.
REQ-007 SHALL have the same AR/R port set for dcache, with prefix I_dcache_/O_dcache_.
REQ-008 SHALL have dcache write ports:
- I_dcache_awvalid, I_dcache_awaddr, I_dcache_awlen, I_dcache_awsize, O_dcache_awready.
- I_dcache_wvalid, I_dcache_wdata, I_dcache_wstrb[7:0], I_dcache_wlast, O_dcache_wready.
- O_dcache_bvalid, I_dcache_bready.
REQ-009 SHALL have master ports O_mem_ar*/I_mem_arready, I_mem_r*/O_mem_rready, O_mem_aw*/I_mem_awready, O_mem_w*/I_mem_wready, I_mem_bvalid/O_mem_bready, with widths matching REQ-005..008.

Function
REQ-010 SHALL run read FSM states R_IDLE, R_ADDR, R_DATA.
REQ-011 SHALL run write FSM states W_IDLE, W_ADDR, W_DATA, W_RESP.
REQ-012 In R_IDLE, SHALL grant on any eligible arvalid: latch the grant (rgnt: 0=icache, 1=dcache), latch araddr/arlen/arsize, then go to R_ADDR next cycle.
REQ-013 SHALL assert O_<gnt>_arready for exactly one cycle, the grant cycle; the requester request is consumed there.
REQ-014 In R_ADDR, SHALL drive O_mem_arvalid=1 with the latched fields, which stay stable until I_mem_arready; on that handshake go to R_DATA.
REQ-015 In R_DATA, SHALL route I_mem_rvalid/rdata/rlast only to the granted requester, with O_mem_rready = I_<gnt>_rready.
REQ-016 SHALL hold the non-granted requester's rvalid at 0.
REQ-017 On the R handshake with rlast=1, SHALL return to R_IDLE; the earliest next grant is the following cycle.
REQ-018 Dcache read SHALL be ineligible while the write FSM is not W_IDLE (read-after-write ordering); icache eligibility SHALL be unaffected.
REQ-019 On a W_IDLE awvalid, SHALL latch aw fields, pulse O_dcache_awready one cycle, and go to W_ADDR.
REQ-020 In W_ADDR, SHALL drive O_mem_awvalid until I_mem_awready, then go to W_DATA.
REQ-021 In W_DATA, SHALL pass W combinationally: O_mem_wvalid=I_dcache_wvalid, O_dcache_wready=I_mem_wready.
REQ-022 On a W handshake with wlast, SHALL go to W_RESP.
REQ-023 In W_RESP, SHALL pass bvalid/bready; on the handshake, go to W_IDLE.
REQ-024 SHALL let the read and write FSMs operate concurrently and independently, except for REQ-018.
REQ-025 SHALL ignore bresp/rresp/ids; O_mem_arid/awid=0, arburst/awburst=2'b01 (INCR).
REQ-026 Outputs in idle states SHALL be valid=0, ready=0, data/addr=0.

Reset
REQ-027 With I_rst high at a clock edge, both FSMs SHALL enter idle, rgnt=0, the RR pointer=0, and all latched fields=0, even mid-burst; all valid/ready outputs SHALL be 0 the cycle after.
REQ-028 SHALL not complete or drain in-flight bursts across reset.

Configuration
REQ-029 SHALL support macro YSYX_22040750_ARB_RR_EN.
- Defined: on simultaneous eligible requests, grant round-robin; the pointer flips to the other requester after each completed read burst.
- Undefined: fixed priority, dcache over icache.
- Single requests are granted identically in both builds.

Verification
REQ-030 Icache-only read at 0x8000_0000, arlen=1, arready delayed 3 cycles -> one AR issued with that addr; 2 beats reach icache only; last beat has rlast=1; dcache rvalid stays 0.
REQ-031 Simultaneous icache and dcache arvalid, fixed build -> dcache granted first, icache granted the cycle after dcache rlast.
REQ-032 Same stimulus in RR build, repeated 4 times -> grants alternate d,i,d,i.
REQ-033 Dcache write at 0x8000_1000 (2 beats, wstrb=0xFF) pending in W_DATA while dcache arvalid is high -> no dcache AR until bvalid/bready; a concurrent icache read completes meanwhile.
REQ-034 I_rst asserted during R_DATA beat 1 of 2 -> next cycle arvalid=rready=0 and FSM idle; a new icache request is then granted normally.
REQ-035 Master rready held low by requester (I_icache_rready=0) for 5 cycles -> O_mem_rready=0, no beat lost, data delivered in order.

Source files
------------

// File: rtl/ysyx_22040750_axi_arbiter.sv
// ysyx_22040750_axi_arbiter
// Two-requester AXI arbiter: icache (read only) and dcache (read + write)
// share one AXI master port. Independent read and write engines; dcache
// reads are held off while a dcache write is in flight.
// Build option: define YSYX_22040750_ARB_RR_EN for round-robin on
// simultaneous reads; otherwise dcache has fixed priority over icache.

module ysyx_22040750_axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              I_clk,
  input  logic              I_rst,

  // icache read requester
  input  logic              I_icache_arvalid,
  input  logic [ADDR_W-1:0] I_icache_araddr,
  input  logic [7:0]        I_icache_arlen,
  input  logic [2:0]        I_icache_arsize,
  output logic              O_icache_arready,
  output logic              O_icache_rvalid,
  output logic [DATA_W-1:0] O_icache_rdata,
  output logic              O_icache_rlast,
  input  logic              I_icache_rready,

  // dcache read requester
  input  logic              I_dcache_arvalid,
  input  logic [ADDR_W-1:0] I_dcache_araddr,
  input  logic [7:0]        I_dcache_arlen,
  input  logic [2:0]        I_dcache_arsize,
  output logic              O_dcache_arready,
  output logic              O_dcache_rvalid,
  output logic [DATA_W-1:0] O_dcache_rdata,
  output logic              O_dcache_rlast,
  input  logic              I_dcache_rready,

  // dcache write requester
  input  logic              I_dcache_awvalid,
  input  logic [ADDR_W-1:0] I_dcache_awaddr,
  input  logic [7:0]        I_dcache_awlen,
  input  logic [2:0]        I_dcache_awsize,
  output logic              O_dcache_awready,
  input  logic              I_dcache_wvalid,
  input  logic [DATA_W-1:0] I_dcache_wdata,
  input  logic [7:0]        I_dcache_wstrb,
  input  logic              I_dcache_wlast,
  output logic              O_dcache_wready,
  output logic              O_dcache_bvalid,
  input  logic              I_dcache_bready,

  // AXI master: read address / data
  output logic              O_mem_arvalid,
  output logic [ADDR_W-1:0] O_mem_araddr,
  output logic [7:0]        O_mem_arlen,
  output logic [2:0]        O_mem_arsize,
  output logic [3:0]        O_mem_arid,
  output logic [1:0]        O_mem_arburst,
  input  logic              I_mem_arready,
  input  logic              I_mem_rvalid,
  input  logic [DATA_W-1:0] I_mem_rdata,
  input  logic              I_mem_rlast,
  output logic              O_mem_rready,

  // AXI master: write address / data / response
  output logic              O_mem_awvalid,
  output logic [ADDR_W-1:0] O_mem_awaddr,
  output logic [7:0]        O_mem_awlen,
  output logic [2:0]        O_mem_awsize,
  output logic [3:0]        O_mem_awid,
  output logic [1:0]        O_mem_awburst,
  input  logic              I_mem_awready,
  output logic              O_mem_wvalid,
  output logic [DATA_W-1:0] O_mem_wdata,
  output logic [7:0]        O_mem_wstrb,
  output logic              O_mem_wlast,
  input  logic              I_mem_wready,
  input  logic              I_mem_bvalid,
  output logic              O_mem_bready
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;

  rd_state_t         r_rstate;
  wr_state_t         r_wstate;
  logic              r_rgnt;       // 0 = icache, 1 = dcache
  logic              r_rst_hold;   // high for the cycle right after reset
  logic [ADDR_W-1:0] r_araddr;
  logic [7:0]        r_arlen;
  logic [2:0]        r_arsize;
  logic [ADDR_W-1:0] r_awaddr;
  logic [7:0]        r_awlen;
  logic [2:0]        r_awsize;

  logic w_i_elig;
  logic w_d_elig;
  logic w_gnt_i;
  logic w_gnt_d;
  logic w_awgnt;
  logic w_rd_data;
  logic w_mem_rready;
  logic w_r_done;
  logic w_wr_data;
  logic w_wr_resp;

`ifdef YSYX_22040750_ARB_RR_EN
  logic r_rr_ptr;                  // 1 = icache wins the next tie

  // Round-robin pointer: after a burst completes, the other requester wins ties
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_rr_ptr <= 1'b0;
    end else if (w_r_done) begin
      r_rr_ptr <= r_rgnt;
    end
  end
`endif

  // No grants in the first cycle after reset so every valid/ready output is low
  always_ff @(posedge I_clk) begin
    r_rst_hold <= I_rst;
  end

  // Read grant decision; a grant is also the requester's AR handshake
  always_comb begin
    w_i_elig = I_icache_arvalid;
    w_d_elig = I_dcache_arvalid && (r_wstate == W_IDLE);
    w_gnt_i  = 1'b0;
    w_gnt_d  = 1'b0;
    if ((r_rstate == R_IDLE) && !r_rst_hold) begin
      if (w_i_elig && w_d_elig) begin
`ifdef YSYX_22040750_ARB_RR_EN
        w_gnt_i = r_rr_ptr;
        w_gnt_d = !r_rr_ptr;
`else
        w_gnt_d = 1'b1;
`endif
      end else begin
        w_gnt_i = w_i_elig;
        w_gnt_d = w_d_elig;
      end
    end
  end

  assign w_rd_data    = (r_rstate == R_DATA);
  assign w_mem_rready = w_rd_data && (r_rgnt ? I_dcache_rready : I_icache_rready);
  assign w_r_done     = w_rd_data && I_mem_rvalid && w_mem_rready && I_mem_rlast;

  // Read FSM: latch granted request, issue AR, stream R to the grantee
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_rstate <= R_IDLE;
      r_rgnt   <= 1'b0;
      r_araddr <= '0;
      r_arlen  <= '0;
      r_arsize <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_gnt_d) begin
            r_rgnt   <= 1'b1;
            r_araddr <= I_dcache_araddr;
            r_arlen  <= I_dcache_arlen;
            r_arsize <= I_dcache_arsize;
            r_rstate <= R_ADDR;
          end else if (w_gnt_i) begin
            r_rgnt   <= 1'b0;
            r_araddr <= I_icache_araddr;
            r_arlen  <= I_icache_arlen;
            r_arsize <= I_icache_arsize;
            r_rstate <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (I_mem_arready) begin
            r_rstate <= R_DATA;
          end
        end
        R_DATA: begin
          if (w_r_done) begin
            r_rstate <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign w_awgnt   = (r_wstate == W_IDLE) && I_dcache_awvalid && !r_rst_hold;
  assign w_wr_data = (r_wstate == W_DATA);
  assign w_wr_resp = (r_wstate == W_RESP);

  // Write FSM: latch AW, issue AW, pass W through, pass B back
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_wstate <= W_IDLE;
      r_awaddr <= '0;
      r_awlen  <= '0;
      r_awsize <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_awgnt) begin
            r_awaddr <= I_dcache_awaddr;
            r_awlen  <= I_dcache_awlen;
            r_awsize <= I_dcache_awsize;
            r_wstate <= W_ADDR;
          end
        end
        W_ADDR: begin
          if (I_mem_awready) begin
            r_wstate <= W_DATA;
          end
        end
        W_DATA: begin
          if (I_dcache_wvalid && I_mem_wready && I_dcache_wlast) begin
            r_wstate <= W_RESP;
          end
        end
        W_RESP: begin
          if (I_mem_bvalid && I_dcache_bready) begin
            r_wstate <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Requester-side read outputs
  assign O_icache_arready = w_gnt_i;
  assign O_dcache_arready = w_gnt_d;
  assign O_icache_rvalid  = w_rd_data && !r_rgnt && I_mem_rvalid;
  assign O_icache_rdata   = (w_rd_data && !r_rgnt) ? I_mem_rdata : '0;
  assign O_icache_rlast   = w_rd_data && !r_rgnt && I_mem_rlast;
  assign O_dcache_rvalid  = w_rd_data && r_rgnt && I_mem_rvalid;
  assign O_dcache_rdata   = (w_rd_data && r_rgnt) ? I_mem_rdata : '0;
  assign O_dcache_rlast   = w_rd_data && r_rgnt && I_mem_rlast;

  // Master-side read outputs
  assign O_mem_arvalid = (r_rstate == R_ADDR);
  assign O_mem_araddr  = (r_rstate == R_ADDR) ? r_araddr : '0;
  assign O_mem_arlen   = (r_rstate == R_ADDR) ? r_arlen  : '0;
  assign O_mem_arsize  = (r_rstate == R_ADDR) ? r_arsize : '0;
  assign O_mem_arid    = '0;
  assign O_mem_arburst = 2'b01;
  assign O_mem_rready  = w_mem_rready;

  // Write-side outputs
  assign O_dcache_awready = w_awgnt;
  assign O_dcache_wready  = w_wr_data && I_mem_wready;
  assign O_dcache_bvalid  = w_wr_resp && I_mem_bvalid;
  assign O_mem_awvalid    = (r_wstate == W_ADDR);
  assign O_mem_awaddr     = (r_wstate == W_ADDR) ? r_awaddr : '0;
  assign O_mem_awlen      = (r_wstate == W_ADDR) ? r_awlen  : '0;
  assign O_mem_awsize     = (r_wstate == W_ADDR) ? r_awsize : '0;
  assign O_mem_awid       = '0;
  assign O_mem_awburst    = 2'b01;
  assign O_mem_wvalid     = w_wr_data && I_dcache_wvalid;
  assign O_mem_wdata      = w_wr_data ? I_dcache_wdata : '0;
  assign O_mem_wstrb      = w_wr_data ? I_dcache_wstrb : '0;
  assign O_mem_wlast      = w_wr_data && I_dcache_wlast;
  assign O_mem_bready     = w_wr_resp && I_dcache_bready;

endmodule
